// File: rtl/ifid_pkg.sv
// ifid_pkg: types and constants shared by the fetch-to-decode buffer.
//   COMMON_WIDTH  : datapath width for instructions and PCs
//   NOP_INST      : instruction shown to decode when nothing is queued
//   fetch_entry_t : one queued fetch result {inst, pc}
//   clog2_min1    : pointer width helper, never returns less than 1
package ifid_pkg;

    localparam int COMMON_WIDTH = 32;

    localparam logic [COMMON_WIDTH-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [COMMON_WIDTH-1:0] inst;
        logic [COMMON_WIDTH-1:0] pc;
    } fetch_entry_t;

    // A one-entry queue still needs a one-bit pointer.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// sync_fifo_ptr: head/tail pointer and occupancy bookkeeping for a
// power-of-two deep FIFO. Holds no data.
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   push_i       : write one entry at the tail (ignored when full)
//   pop_i        : retire the head entry (ignored when empty)
//   clear_i      : drop everything; wins over push and pop
//   headPtr_o    : storage index of the oldest entry
//   tailPtr_o    : storage index the next push writes to
//   count_o      : number of valid entries, 0..DEPTH
//   full_o/empty_o : occupancy flags
module sync_fifo_ptr
    import ifid_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = clog2_min1(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [PTR_W-1:0] headPtr_o,
    output logic [PTR_W-1:0] tailPtr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (clear_i) begin
            headPtr_d = '0;
            tailPtr_d = '0;
            count_d   = '0;
        end else begin
            if (doPush) tailPtr_d = tailPtr_q + PTR_W'(1);
            if (doPop)  headPtr_d = headPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
        end
    end

    assign headPtr_o = headPtr_q;
    assign tailPtr_o = tailPtr_q;
    assign count_o   = count_q;

endmodule

// File: rtl/ifid_skid_buffer.sv
// ifid_skid_buffer: receiving end of the fetch-to-decode path. Queues
// {inst, pc} pairs from fetch in a small FIFO and presents the oldest to
// decode; a jump flush drops everything. Also counts decode-starved cycles.
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   in_inst/in_pc       : entry offered by fetch
//   in_valid/in_ready   : fetch handshake; !in_ready is the fetch stall
//   flush               : jump taken, discard queued and offered entries
//   out_inst/out_pc     : head entry (NOP_INST / 0 when empty)
//   out_valid/out_ready : decode handshake
//   starve_cnt          : saturating count of out_ready && !out_valid cycles
// WIDTH is expected to equal ifid_pkg::COMMON_WIDTH.
module ifid_skid_buffer #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP_INST  = ifid_pkg::NOP_INST,
    parameter int               CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_inst,
    input  logic [WIDTH-1:0]     in_pc,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_inst,
    output logic [WIDTH-1:0]     out_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] starve_cnt
);

    import ifid_pkg::*;

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]     headPtr;
    logic [PTR_W-1:0]     tailPtr;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 pushEn;
    logic                 popEn;
    logic                 armed_q;
    logic [CNT_WIDTH-1:0] starveCnt_q, starveCnt_d;
    fetch_entry_t         mem_q [DEPTH];
    fetch_entry_t         headEntry;

    // Held low through reset so fetch stays stalled until the first edge
    // after release, keeping in_ready purely register-derived.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) armed_q <= 1'b0;
        else      armed_q <= 1'b1;
    end

    assign in_ready = armed_q && !full;
    assign pushEn   = in_valid && in_ready && !flush;
    assign popEn    = out_valid && out_ready && !flush;

    sync_fifo_ptr #(
        .DEPTH (DEPTH)
    ) uPtr (
        .clk       (clk),
        .rst       (rst),
        .push_i    (pushEn),
        .pop_i     (popEn),
        .clear_i   (flush),
        .headPtr_o (headPtr),
        .tailPtr_o (tailPtr),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Storage is not reset; validity comes only from count and pointers.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[tailPtr] <= '{inst: in_inst, pc: in_pc};
        end
    end

    assign headEntry = mem_q[headPtr];
    assign out_valid = !empty;
    assign out_inst  = empty ? NOP_INST : headEntry.inst;
    assign out_pc    = empty ? '0 : headEntry.pc;

    // Flush cycles are not counted as starvation; the counter sticks at all ones.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (out_ready && !out_valid && !flush && (starveCnt_q != '1)) begin
            starveCnt_d = starveCnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starveCnt_q <= '0;
        else      starveCnt_q <= starveCnt_d;
    end

    assign starve_cnt = starveCnt_q;

endmodule

// File: doc/ifid_skid_buffer.md
Name: ifid_skid_buffer

Overview:
- Receiving end of the fetch-to-decode path. Accepts an instruction word and its PC from the fetch stage and presents them to decode one cycle later.
- Small FIFO decouples fetch from decode back-pressure. Drops all queued and in-flight entries on a jump flush.
- Its in_ready output drives the fetch stage's stall input, so fetch holds its PC while the buffer is full.
- Saturating counter of decode-starved cycles for performance debug.

Parameters:
- WIDTH, 32, instruction and PC width (matches COMMON_WIDTH).
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- NOP_INST, 32'h0000_0000, instruction presented on the output when the buffer is empty or in reset.
- CNT_WIDTH, 16, width of the starvation counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- in_inst  in  WIDTH  instruction from fetch
- in_pc  in  WIDTH  PC of in_inst
- in_valid  in  1  fetch offers an entry this cycle
- in_ready  out  1  buffer accepts an entry this cycle; inverted, this is the fetch stall
- flush  in  1  jump taken; discard everything
- out_inst  out  WIDTH  instruction to decode
- out_pc  out  WIDTH  PC to decode
- out_valid  out  1  out_inst/out_pc are a real entry
- out_ready  in  1  decode consumes the head this cycle (decode not stalled)
- starve_cnt  out  CNT_WIDTH  cycles with out_ready=1 and out_valid=0, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, head/tail pointers=0, out_valid=0, out_inst=NOP_INST, out_pc=0, starve_cnt=0.
  - in_ready=0 while rst=0; in_ready=1 from the first clock edge after release.
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count < DEPTH), registered-derived only. No combinational path from out_ready.
- Output:
  - out_inst/out_pc/out_valid come directly from the head storage entry and count.
  - Empty: out_valid=0, out_inst=NOP_INST, out_pc=0.
- Latency: an entry pushed at edge N appears at the output after edge N; decode can pop it at edge N+1 (one-cycle latency from empty).
- Simultaneous push and pop:
  - 0 < count < DEPTH: count unchanged, both pointers advance.
  - count == DEPTH: pop only, since in_ready=0; no full pass-through.
  - count == 0: push only, since out_valid=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits and never exceeds DEPTH.
- Flush:
  - At the edge where flush=1: count=0, both pointers=0, out_valid=0 next cycle.
  - Any push offered in the same cycle is discarded; any pop is irrelevant.
  - flush has priority over push and pop.
  - in_ready is 1 the cycle after a flush.
- Starvation counter: increments by 1 at each edge where out_ready && !out_valid && !flush. Saturates at all ones and is cleared only by reset.
- Storage for non-head entries is not reset; only count and pointers define validity.
- Reset mid-operation: all state returns to reset values immediately; queued entries are lost.

Decomposition:
- Shared package ifid_pkg:
  - typedef fetch_entry_t, a packed struct {inst, pc} of 2*WIDTH bits.
  - Constant NOP_INST.
  - Function clog2_min1 for pointer widths.
- One natural sub-module, sync_fifo_ptr: pointer/count bookkeeping with push, pop, clear and full/empty.
- Storage array and output muxing stay in ifid_skid_buffer.

Test Plan:
- Reset then idle, out_ready=1 for 5 cycles:
  - out_valid=0, out_inst=0, in_ready=1 after release.
  - starve_cnt=5.
- Push inst 32'h0000_0013 at pc 32'h0000_1000, out_ready=1:
  - Appears one cycle later with out_valid=1 and out_pc=32'h1000.
  - Popped the next cycle; count back to 0.
- out_ready=0, push pcs 0x00, 0x04, then offer 0x08:
  - in_ready=0 after the second push; 0x08 is held by fetch.
  - Raise out_ready: output order is 0x00, 0x04, then 0x08 (the third entry is pushed once space frees).
- Buffer full (0x10, 0x14), out_ready=1, in_valid=1 with 0x18:
  - First cycle pops 0x10 only; 0x18 is accepted the next cycle.
  - No entry is lost or duplicated.
- One entry queued, assert flush with in_valid=1 (pc 0x40) and jump to 0x80:
  - Next cycle out_valid=0 and pc 0x40 never appears.
  - The following push of 0x80 is the next output.
- Assert rst mid-stream with 2 entries queued:
  - Outputs go to reset values asynchronously, before the next clock edge.
  - After release the buffer is empty and starve_cnt=0.
